// File: rtl/div_ctrl.sv
// Iterative radix-2 shift-subtract divider controller for the EX stage.
// Serves DIV/DIVU, holds the pipeline via stallreq while busy and returns
// {remainder, quotient} with a ready strobe after DATA_W iteration steps.
module div_ctrl #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 6
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start_i,
    input  logic                  signed_i,
    input  logic [DATA_W-1:0]     opdata1_i,
    input  logic [DATA_W-1:0]     opdata2_i,
    input  logic                  annul_i,
    output logic [2*DATA_W-1:0]   result_o,
    output logic                  ready_o,
    output logic                  stallreq
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DIVZERO = 2'd1,
        ST_ON      = 2'd2,
        ST_END     = 2'd3
    } state_t;

    // Counter value during the final iteration step.
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    state_t                 state_q,    state_d;
    logic [CNT_W-1:0]       cnt_q,      cnt_d;
    logic [2*DATA_W-1:0]    dividend_q, dividend_d;
    logic [DATA_W-1:0]      divisor_q,  divisor_d;
    logic                   signQuo_q,  signQuo_d;
    logic                   signRem_q,  signRem_d;
    logic [2*DATA_W-1:0]    result_q,   result_d;
    logic                   ready_q,    ready_d;

    logic [DATA_W-1:0]      op1Abs;
    logic [DATA_W-1:0]      op2Abs;
    logic [DATA_W:0]        stepDiff;
    logic                   stepTake;
    logic [2*DATA_W-1:0]    stepDividend;
    logic [DATA_W-1:0]      quotientFix;
    logic [DATA_W-1:0]      remainderFix;

    // Magnitudes of the operands; negative values only matter for DIV.
    always_comb begin
        op1Abs = opdata1_i;
        op2Abs = opdata2_i;
        if (signed_i && opdata1_i[DATA_W-1]) begin
            op1Abs = -opdata1_i;
        end
        if (signed_i && opdata2_i[DATA_W-1]) begin
            op2Abs = -opdata2_i;
        end
    end

    // One restoring-division step on the working register, plus the sign
    // fix-ups applied to the value the final step produces. A set top bit
    // means the shifted partial remainder already exceeds any divisor, so
    // it forces the subtract just like a missing borrow would.
    always_comb begin
        stepDiff = {1'b0, dividend_q[2*DATA_W-2:DATA_W-1]} - {1'b0, divisor_q};
        stepTake = dividend_q[2*DATA_W-1] | ~stepDiff[DATA_W];
        if (stepTake) begin
            stepDividend = {stepDiff[DATA_W-1:0], dividend_q[DATA_W-2:0], 1'b1};
        end else begin
            stepDividend = {dividend_q[2*DATA_W-2:0], 1'b0};
        end
        quotientFix  = stepDividend[DATA_W-1:0];
        remainderFix = stepDividend[2*DATA_W-1:DATA_W];
        if (signQuo_q) begin
            quotientFix = -stepDividend[DATA_W-1:0];
        end
        if (signRem_q) begin
            remainderFix = -stepDividend[2*DATA_W-1:DATA_W];
        end
    end

    // Next-state and datapath-register update; annul always wins.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        dividend_d = dividend_q;
        divisor_d  = divisor_q;
        signQuo_d  = signQuo_q;
        signRem_d  = signRem_q;
        result_d   = result_q;
        ready_d    = ready_q;

        case (state_q)
            ST_IDLE: begin
                ready_d  = 1'b0;
                result_d = '0;
                if (start_i && !annul_i) begin
                    if (opdata2_i == '0) begin
                        state_d = ST_DIVZERO;
                    end else begin
                        state_d    = ST_ON;
                        cnt_d      = '0;
                        divisor_d  = op2Abs;
                        dividend_d = {{DATA_W{1'b0}}, op1Abs};
                        signQuo_d  = signed_i & (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
                        signRem_d  = signed_i & opdata1_i[DATA_W-1];
                    end
                end
            end

            ST_DIVZERO: begin
                result_d = '0;
                if (annul_i) begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                end else begin
                    state_d = ST_END;
                    ready_d = 1'b1;
                end
            end

            ST_ON: begin
                if (annul_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end else begin
                    dividend_d = stepDividend;
                    cnt_d      = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d  = ST_END;
                        result_d = {remainderFix, quotientFix};
                        ready_d  = 1'b1;
                    end
                end
            end

            ST_END: begin
                if (!start_i || annul_i) begin
                    state_d  = ST_IDLE;
                    ready_d  = 1'b0;
                    result_d = '0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                ready_d  = 1'b0;
                result_d = '0;
            end
        endcase
    end

    // Hold the pipeline from the request cycle until the result is ready.
    always_comb begin
        stallreq = 1'b0;
        case (state_q)
            ST_IDLE:    stallreq = start_i & ~annul_i;
            ST_DIVZERO: stallreq = 1'b1;
            ST_ON:      stallreq = 1'b1;
            default:    stallreq = 1'b0;
        endcase
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            dividend_q <= '0;
            divisor_q  <= '0;
            signQuo_q  <= 1'b0;
            signRem_q  <= 1'b0;
            result_q   <= '0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            dividend_q <= dividend_d;
            divisor_q  <= divisor_d;
            signQuo_q  <= signQuo_d;
            signRem_q  <= signRem_d;
            result_q   <= result_d;
            ready_q    <= ready_d;
        end
    end

    assign result_o = result_q;
    assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_ctrl.sv
// Scoreboard testbench for div_ctrl: directed cases plus randomized DIV/DIVU
// operations checked against an arithmetic reference model.
module tb_div_ctrl;

    localparam int DATA_W = 32;

    logic                 clk = 1'b0;
    logic                 rst;
    logic                 start_i;
    logic                 signed_i;
    logic [DATA_W-1:0]    opdata1_i;
    logic [DATA_W-1:0]    opdata2_i;
    logic                 annul_i;
    logic [2*DATA_W-1:0]  result_o;
    logic                 ready_o;
    logic                 stallreq;

    int                   checkCount = 0;
    int                   passCount  = 0;
    logic [63:0]          expQ[$];
    logic                 readyPrev = 1'b0;

    div_ctrl #(.DATA_W(DATA_W), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start_i   (start_i),
        .signed_i  (signed_i),
        .opdata1_i (opdata1_i),
        .opdata2_i (opdata2_i),
        .annul_i   (annul_i),
        .result_o  (result_o),
        .ready_o   (ready_o),
        .stallreq  (stallreq)
    );

    // Free-running clock, 10 time units per period.
    always #5 clk = ~clk;

    // Reference: plain 64-bit integer division, truncating toward zero.
    function automatic logic [63:0] refModel(input logic [31:0] a, input logic [31:0] b, input logic sgn);
        longint sa;
        longint sb;
        longint q;
        longint r;
        if (b == 32'd0) return 64'd0;
        if (sgn) begin
            sa = {{32{a[31]}}, a};
            sb = {{32{b[31]}}, b};
        end else begin
            sa = {32'd0, a};
            sb = {32'd0, b};
        end
        q = sa / sb;
        r = sa % sb;
        return {r[31:0], q[31:0]};
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: whenever ready rises, pop the oldest expected result and compare.
    always @(negedge clk) begin
        if (rst && ready_o && !readyPrev) begin
            if (expQ.size() == 0) begin
                checkOutput("spurious ready", 64'(ready_o), 64'd0);
            end else begin
                checkOutput("result", result_o, expQ.pop_front());
            end
        end
        readyPrev = ready_o;
    end

    // abortKind: 0 = run to completion, 1 = annul at ON cycle abortAt,
    // 2 = async reset between edges at ON cycle abortAt.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b, input logic sgn,
                                 input int abortKind, input int abortAt, input int holdCycles);
        int          cycles;
        int          expLat;
        bit          seen;
        logic [63:0] expVal;
        expVal = refModel(a, b, sgn);
        expLat = (b == 32'd0) ? 2 : 33;
        @(negedge clk);
        opdata1_i = a;
        opdata2_i = b;
        signed_i  = sgn;
        annul_i   = 1'b0;
        start_i   = 1'b1;
        #1;
        checkOutput("stallreq on request", 64'(stallreq), 64'd1);
        if (abortKind == 0) expQ.push_back(expVal);
        cycles = 0;
        seen   = 1'b0;
        while (!seen && cycles < 100) begin
            @(posedge clk);
            #1;
            cycles++;
            if (ready_o) begin
                seen = 1'b1;
                checkOutput("latency", 64'(cycles), 64'(expLat));
                checkOutput("stallreq low in END", 64'(stallreq), 64'd0);
            end else begin
                checkOutput("stallreq while busy", 64'(stallreq), 64'd1);
                if (abortKind == 1 && cycles == abortAt) begin
                    annul_i = 1'b1;
                    @(posedge clk);
                    #1;
                    checkOutput("ready after annul", 64'(ready_o), 64'd0);
                    checkOutput("stallreq after annul", 64'(stallreq), 64'd0);
                    start_i = 1'b0;
                    annul_i = 1'b0;
                    return;
                end
                if (abortKind == 2 && cycles == abortAt) begin
                    #2;
                    rst     = 1'b0;
                    start_i = 1'b0;
                    #1;
                    checkOutput("ready after reset", 64'(ready_o), 64'd0);
                    checkOutput("result after reset", result_o, 64'd0);
                    checkOutput("stallreq after reset", 64'(stallreq), 64'd0);
                    @(negedge clk);
                    rst = 1'b1;
                    return;
                end
            end
        end
        if (!seen) begin
            checkOutput("ready timeout", 64'(ready_o), 64'd1);
        end
        for (int i = 0; i < holdCycles; i++) begin
            @(posedge clk);
            #1;
            checkOutput("ready held in END", 64'(ready_o), 64'd1);
            checkOutput("result held in END", result_o, expVal);
        end
        @(negedge clk);
        start_i = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("ready after release", 64'(ready_o), 64'd0);
        checkOutput("result after release", result_o, 64'd0);
    endtask

    // Guard against a hung run.
    initial begin
        #2000000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    // Main stimulus sequence.
    initial begin
        logic [31:0] ra;
        logic [31:0] rb;
        logic        rs;
        rst       = 1'b0;
        start_i   = 1'b0;
        signed_i  = 1'b0;
        annul_i   = 1'b0;
        opdata1_i = '0;
        opdata2_i = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset result", result_o, 64'd0);
        checkOutput("reset ready", 64'(ready_o), 64'd0);
        checkOutput("reset stallreq", 64'(stallreq), 64'd0);
        @(negedge clk);
        rst = 1'b1;

        applyStimulus(32'd100,        32'd7,          1'b0, 0, 0, 3);
        applyStimulus(32'hFFFFFFF9,   32'd2,          1'b1, 0, 0, 0);
        applyStimulus(32'h80000000,   32'hFFFFFFFF,   1'b1, 0, 0, 0);
        applyStimulus(32'hFFFFFFFF,   32'd1,          1'b0, 0, 0, 0);
        applyStimulus(32'd5,          32'd9,          1'b0, 0, 0, 0);
        applyStimulus(32'd123,        32'd0,          1'b1, 0, 0, 2);
        applyStimulus(32'd1000,       32'd7,          1'b0, 1, 10, 0);
        applyStimulus(32'd9,          32'd3,          1'b0, 0, 0, 0);
        applyStimulus(32'd12345,      32'd6,          1'b0, 2, 20, 0);
        applyStimulus(32'd10,         32'd4,          1'b0, 0, 0, 0);

        for (int n = 0; n < 24; n++) begin
            ra = $urandom;
            rs = 1'($urandom_range(0, 1));
            case ($urandom_range(0, 3))
                0:       rb = $urandom;
                1:       rb = 32'($urandom_range(1, 15));
                2:       rb = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 1000));
                default: rb = 32'hFFFFFFFF - 32'($urandom_range(0, 7));
            endcase
            applyStimulus(ra, rb, rs, 0, 0, 0);
        end

        repeat (3) @(posedge clk);
        #1;
        checkOutput("scoreboard drained", 64'(expQ.size()), 64'd0);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
